// File: rtl/gemm_loop_seq.sv
// GEMM loop-nest sequencer: walks (i,j,k) over a uop range and drives buffer reads and acc writeback.
// Define GEMM_RAW_STALL_EN to add the accumulator read-after-write interlock.
module gemm_loop_seq #(
   parameter int UOP_AW  = 11,
   parameter int ACC_AW  = 11,
   parameter int INP_AW  = 11,
   parameter int WGT_AW  = 10,
   parameter int LOOP_W  = 14,
   parameter int RD_LAT  = 1,
   parameter int MAC_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [UOP_AW-1:0] cmd_uop_bgn,
   input  logic [UOP_AW-1:0] cmd_uop_end,
   input  logic [LOOP_W-1:0] cmd_lp_out,
   input  logic [LOOP_W-1:0] cmd_lp_in,
   input  logic [ACC_AW-1:0] cmd_acc_f_out,
   input  logic [ACC_AW-1:0] cmd_acc_f_in,
   input  logic [INP_AW-1:0] cmd_inp_f_out,
   input  logic [INP_AW-1:0] cmd_inp_f_in,
   input  logic [WGT_AW-1:0] cmd_wgt_f_out,
   input  logic [WGT_AW-1:0] cmd_wgt_f_in,
   input  logic              cmd_reset,
   output logic              uop_rd_en,
   output logic [UOP_AW-1:0] uop_addr,
   input  logic [ACC_AW-1:0] uop_acc,
   input  logic [INP_AW-1:0] uop_inp,
   input  logic [WGT_AW-1:0] uop_wgt,
   output logic              inp_rd_en,
   output logic [INP_AW-1:0] inp_addr,
   output logic              wgt_rd_en,
   output logic [WGT_AW-1:0] wgt_addr,
   output logic              acc_rd_en,
   output logic [ACC_AW-1:0] acc_addr,
   output logic              acc_wr_en,
   output logic [ACC_AW-1:0] acc_wr_addr,
   output logic              acc_wr_zero,
   output logic              busy,
   output logic              done
);

   localparam int WB_LAT = RD_LAT + MAC_LAT;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state, state_nx;

   logic [UOP_AW-1:0] uop_bgn, uop_end, k;
   logic [LOOP_W-1:0] lp_out, lp_in, i, j;
   logic [ACC_AW-1:0] acc_f_out, acc_f_in, acc_base, acc_off;
   logic [INP_AW-1:0] inp_f_out, inp_f_in, inp_base, inp_off;
   logic [WGT_AW-1:0] wgt_f_out, wgt_f_in, wgt_base, wgt_off;
   logic              zero_mode;

   logic              s1_valid;
   logic [ACC_AW-1:0] s1_acc_off;
   logic [INP_AW-1:0] s1_inp_off;
   logic [WGT_AW-1:0] s1_wgt_off;
   logic              s2_valid;

   logic [WB_LAT-1:0] wb_valid;
   logic [ACC_AW-1:0] wb_addr [WB_LAT];

   logic [ACC_AW-1:0] f_acc;
   logic [INP_AW-1:0] f_inp;
   logic [WGT_AW-1:0] f_wgt;
   logic [ACC_AW-1:0] nxt_acc;
   logic              stall;
   logic              issue;
   logic              k_last, j_last, i_last;
   logic              degen;
   logic              pend;

   assign degen = (cmd_lp_out == '0) || (cmd_lp_in == '0) ||
                  (cmd_uop_end <= cmd_uop_bgn);

   assign k_last = (k == uop_end - UOP_AW'(1));
   assign j_last = (j == lp_in - LOOP_W'(1));
   assign i_last = (i == lp_out - LOOP_W'(1));
   assign issue  = (state == RUN) && !stall;

   assign nxt_acc = f_acc + s1_acc_off;

`ifdef GEMM_RAW_STALL_EN
   logic              held;
   logic [ACC_AW-1:0] h_acc;
   logic [INP_AW-1:0] h_inp;
   logic [WGT_AW-1:0] h_wgt;
   logic              hit;

   assign f_acc = held ? h_acc : uop_acc;
   assign f_inp = held ? h_inp : uop_inp;
   assign f_wgt = held ? h_wgt : uop_wgt;

   // The entry in the last writeback slot retires this cycle, so it is
   // not a hazard for a read driven next cycle.
   always_comb begin
      hit = s2_valid && (acc_addr == nxt_acc);
      for (int e = 0; e < WB_LAT - 1; e++)
         if (wb_valid[e] && (wb_addr[e] == nxt_acc)) hit = 1'b1;
   end

   assign stall = s1_valid && !zero_mode && hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         held  <= 1'b0;
         h_acc <= '0;
         h_inp <= '0;
         h_wgt <= '0;
      end else if (stall) begin
         held  <= 1'b1;
         h_acc <= f_acc;
         h_inp <= f_inp;
         h_wgt <= f_wgt;
      end else begin
         held  <= 1'b0;
      end
   end
`else
   assign f_acc = uop_acc;
   assign f_inp = uop_inp;
   assign f_wgt = uop_wgt;
   assign stall = 1'b0;
`endif

   always_comb begin
      pend = s1_valid | s2_valid;
      for (int e = 0; e < WB_LAT - 1; e++) pend = pend | wb_valid[e];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (cmd_valid) state_nx = degen ? DONE : RUN;
         RUN:     if (issue && k_last && j_last && i_last) state_nx = DRAIN;
         DRAIN:   if (!pend) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign uop_rd_en = issue;
   assign uop_addr  = issue ? k : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         uop_bgn   <= '0;
         uop_end   <= '0;
         lp_out    <= '0;
         lp_in     <= '0;
         acc_f_out <= '0;
         acc_f_in  <= '0;
         inp_f_out <= '0;
         inp_f_in  <= '0;
         wgt_f_out <= '0;
         wgt_f_in  <= '0;
         zero_mode <= 1'b0;
         k         <= '0;
         i         <= '0;
         j         <= '0;
         acc_base  <= '0;
         acc_off   <= '0;
         inp_base  <= '0;
         inp_off   <= '0;
         wgt_base  <= '0;
         wgt_off   <= '0;
      end else if (state == IDLE && cmd_valid) begin
         uop_bgn   <= cmd_uop_bgn;
         uop_end   <= cmd_uop_end;
         lp_out    <= cmd_lp_out;
         lp_in     <= cmd_lp_in;
         acc_f_out <= cmd_acc_f_out;
         acc_f_in  <= cmd_acc_f_in;
         inp_f_out <= cmd_inp_f_out;
         inp_f_in  <= cmd_inp_f_in;
         wgt_f_out <= cmd_wgt_f_out;
         wgt_f_in  <= cmd_wgt_f_in;
         zero_mode <= cmd_reset;
         k         <= cmd_uop_bgn;
         i         <= '0;
         j         <= '0;
         acc_base  <= '0;
         acc_off   <= '0;
         inp_base  <= '0;
         inp_off   <= '0;
         wgt_base  <= '0;
         wgt_off   <= '0;
      end else if (issue) begin
         if (!k_last) begin
            k <= k + UOP_AW'(1);
         end else begin
            k <= uop_bgn;
            if (!j_last) begin
               j       <= j + LOOP_W'(1);
               acc_off <= acc_off + acc_f_in;
               inp_off <= inp_off + inp_f_in;
               wgt_off <= wgt_off + wgt_f_in;
            end else begin
               // Outer step: inner offset restarts from the new outer base.
               j        <= '0;
               i        <= i + LOOP_W'(1);
               acc_base <= acc_base + acc_f_out;
               acc_off  <= acc_base + acc_f_out;
               inp_base <= inp_base + inp_f_out;
               inp_off  <= inp_base + inp_f_out;
               wgt_base <= wgt_base + wgt_f_out;
               wgt_off  <= wgt_base + wgt_f_out;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_acc_off <= '0;
         s1_inp_off <= '0;
         s1_wgt_off <= '0;
      end else if (issue) begin
         s1_valid   <= 1'b1;
         s1_acc_off <= acc_off;
         s1_inp_off <= inp_off;
         s1_wgt_off <= wgt_off;
      end else if (!stall) begin
         s1_valid   <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid  <= 1'b0;
         acc_rd_en <= 1'b0;
         inp_rd_en <= 1'b0;
         wgt_rd_en <= 1'b0;
         acc_addr  <= '0;
         inp_addr  <= '0;
         wgt_addr  <= '0;
      end else if (s1_valid && !stall) begin
         s2_valid  <= 1'b1;
         acc_rd_en <= !zero_mode;
         inp_rd_en <= !zero_mode;
         wgt_rd_en <= !zero_mode;
         acc_addr  <= nxt_acc;
         inp_addr  <= f_inp + s1_inp_off;
         wgt_addr  <= f_wgt + s1_wgt_off;
      end else begin
         s2_valid  <= 1'b0;
         acc_rd_en <= 1'b0;
         inp_rd_en <= 1'b0;
         wgt_rd_en <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid <= '0;
         for (int e = 0; e < WB_LAT; e++) wb_addr[e] <= '0;
      end else begin
         wb_valid[0] <= s2_valid;
         wb_addr[0]  <= acc_addr;
         for (int e = 1; e < WB_LAT; e++) begin
            wb_valid[e] <= wb_valid[e-1];
            wb_addr[e]  <= wb_addr[e-1];
         end
      end
   end

   assign acc_wr_en   = wb_valid[WB_LAT-1];
   assign acc_wr_addr = wb_addr[WB_LAT-1];
   assign acc_wr_zero = wb_valid[WB_LAT-1] & zero_mode;

endmodule

// File: tb/tb_gemm_loop_seq.sv
// Directed bench for gemm_loop_seq: single op, loop nest, zero mode,
// degenerate commands, wrap-around, mid-op reset and acc RAW ordering.
module tb_gemm_loop_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [10:0] cmd_uop_bgn, cmd_uop_end;
   logic [13:0] cmd_lp_out, cmd_lp_in;
   logic [10:0] cmd_acc_f_out, cmd_acc_f_in;
   logic [10:0] cmd_inp_f_out, cmd_inp_f_in;
   logic [9:0]  cmd_wgt_f_out, cmd_wgt_f_in;
   logic        cmd_reset;
   logic        uop_rd_en;
   logic [10:0] uop_addr;
   logic [10:0] uop_acc = '0;
   logic [10:0] uop_inp = '0;
   logic [9:0]  uop_wgt = '0;
   logic        inp_rd_en, wgt_rd_en, acc_rd_en;
   logic [10:0] inp_addr, acc_addr;
   logic [9:0]  wgt_addr;
   logic        acc_wr_en, acc_wr_zero;
   logic [10:0] acc_wr_addr;
   logic        busy, done;

   always #5 clk = ~clk;

   gemm_loop_seq dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_uop_bgn(cmd_uop_bgn), .cmd_uop_end(cmd_uop_end),
      .cmd_lp_out(cmd_lp_out), .cmd_lp_in(cmd_lp_in),
      .cmd_acc_f_out(cmd_acc_f_out), .cmd_acc_f_in(cmd_acc_f_in),
      .cmd_inp_f_out(cmd_inp_f_out), .cmd_inp_f_in(cmd_inp_f_in),
      .cmd_wgt_f_out(cmd_wgt_f_out), .cmd_wgt_f_in(cmd_wgt_f_in),
      .cmd_reset(cmd_reset),
      .uop_rd_en(uop_rd_en), .uop_addr(uop_addr),
      .uop_acc(uop_acc), .uop_inp(uop_inp), .uop_wgt(uop_wgt),
      .inp_rd_en(inp_rd_en), .inp_addr(inp_addr),
      .wgt_rd_en(wgt_rd_en), .wgt_addr(wgt_addr),
      .acc_rd_en(acc_rd_en), .acc_addr(acc_addr),
      .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr),
      .acc_wr_zero(acc_wr_zero),
      .busy(busy), .done(done)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // uop memory, one-cycle read
   logic [10:0] m_acc [16];
   logic [10:0] m_inp [16];
   logic [9:0]  m_wgt [16];
   always @(posedge clk)
      if (uop_rd_en) begin
         uop_acc <= m_acc[uop_addr[3:0]];
         uop_inp <= m_inp[uop_addr[3:0]];
         uop_wgt <= m_wgt[uop_addr[3:0]];
      end

   int          wr_cyc_q[$];
   logic [10:0] wr_addr_q[$];
   logic        wr_zero_q[$];
   int          ard_cyc_q[$];
   logic [10:0] ard_q[$];
   logic [10:0] ird_q[$];
   logic [9:0]  grd_q[$];
   int          f_cyc_q[$];
   logic [10:0] f_q[$];
   int          done_q[$];
   int          rd_cnt = 0;

   always @(negedge clk) begin
      if (acc_wr_en) begin
         wr_cyc_q.push_back(cyc);
         wr_addr_q.push_back(acc_wr_addr);
         wr_zero_q.push_back(acc_wr_zero);
      end
      if (acc_rd_en) begin
         ard_cyc_q.push_back(cyc);
         ard_q.push_back(acc_addr);
      end
      if (inp_rd_en) ird_q.push_back(inp_addr);
      if (wgt_rd_en) grd_q.push_back(wgt_addr);
      if (acc_rd_en | inp_rd_en | wgt_rd_en) rd_cnt = rd_cnt + 1;
      if (uop_rd_en) begin
         f_cyc_q.push_back(cyc);
         f_q.push_back(uop_addr);
      end
      if (done) done_q.push_back(cyc);
   end

   int checks = 0;
   int errors = 0;
   int wb, ab, ib, gb, fb, db, rb;

   task automatic send_cmd(
      input logic [10:0] bgn, input logic [10:0] endv,
      input logic [13:0] lo, input logic [13:0] li,
      input logic [10:0] afo, input logic [10:0] afi,
      input logic [10:0] ifo, input logic [10:0] ifi,
      input logic [9:0] gfo, input logic [9:0] gfi,
      input logic zr, output int n);
      wb = wr_addr_q.size(); ab = ard_q.size(); ib = ird_q.size();
      gb = grd_q.size(); fb = f_q.size(); db = done_q.size(); rb = rd_cnt;
      cmd_uop_bgn = bgn; cmd_uop_end = endv;
      cmd_lp_out = lo; cmd_lp_in = li;
      cmd_acc_f_out = afo; cmd_acc_f_in = afi;
      cmd_inp_f_out = ifo; cmd_inp_f_in = ifi;
      cmd_wgt_f_out = gfo; cmd_wgt_f_in = gfi;
      cmd_reset = zr;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      n = cyc;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(output bit got);
      got = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         #1;
         if (done_q.size() > db) begin
            got = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %b want 1", cmd_ready);
      end
      checks++;
      if ({uop_rd_en, inp_rd_en, wgt_rd_en, acc_rd_en, acc_wr_en,
           acc_wr_zero, busy, done} !== 8'h00) begin
         errors++;
         $display("FAIL reset_strobes got %b want 0", {uop_rd_en, inp_rd_en,
                  wgt_rd_en, acc_rd_en, acc_wr_en, acc_wr_zero, busy, done});
      end
      checks++;
      if ((uop_addr | inp_addr | acc_addr | acc_wr_addr | 11'(wgt_addr)) !== 11'd0) begin
         errors++;
         $display("FAIL reset_addrs got nonzero want 0");
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      int n;
      bit got;
      m_acc[0] = 11'd5; m_inp[0] = 11'd3; m_wgt[0] = 10'd7;
      send_cmd(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1'b0, n);
      wait_done(got);
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL single_done got timeout want pulse");
      end
      checks++;
      if (f_q.size() - fb != 1 || f_q[fb] !== 11'd0 || f_cyc_q[fb] != n) begin
         errors++;
         $display("FAIL single_fetch got cnt %0d want 1 at cyc %0d addr 0",
                  f_q.size() - fb, n);
      end
      checks++;
      if (ard_q.size() - ab != 1 || ard_q[ab] !== 11'd5 || ard_cyc_q[ab] != n + 2) begin
         errors++;
         $display("FAIL single_acc_rd got cnt %0d want acc 5 at %0d", ard_q.size() - ab, n + 2);
      end
      checks++;
      if (ird_q.size() - ib != 1 || ird_q[ib] !== 11'd3 ||
          grd_q.size() - gb != 1 || grd_q[gb] !== 10'd7) begin
         errors++;
         $display("FAIL single_inp_wgt got cnt %0d/%0d want inp 3 wgt 7",
                  ird_q.size() - ib, grd_q.size() - gb);
      end
      checks++;
      if (wr_addr_q.size() - wb != 1 || wr_addr_q[wb] !== 11'd5 ||
          wr_cyc_q[wb] != n + 4 || wr_zero_q[wb] !== 1'b0) begin
         errors++;
         $display("FAIL single_wr got cnt %0d want addr 5 at %0d zero 0",
                  wr_addr_q.size() - wb, n + 4);
      end
      checks++;
      if (got && done_q[db] != n + 5) begin
         errors++;
         $display("FAIL single_done_cyc got %0d want %0d", done_q[db], n + 5);
      end
      @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_idle got busy %b ready %b want 0 1", busy, cmd_ready);
      end
   endtask

   task automatic run_nest(input logic zr);
      int n;
      bit got;
      int ii, jj, kk;
      logic [10:0] ea, ei;
      logic [9:0]  eg;
      m_acc[0] = 11'd0;  m_acc[1] = 11'd1;
      m_inp[0] = 11'd2;  m_inp[1] = 11'd3;
      m_wgt[0] = 10'd7;  m_wgt[1] = 10'd8;
      send_cmd(0, 2, 2, 3, 16, 4, 100, 10, 1, 0, zr, n);
      wait_done(got);
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL nest_done zr=%b got timeout want pulse", zr);
      end
      checks++;
      if (wr_addr_q.size() - wb != 12) begin
         errors++;
         $display("FAIL nest_wr_cnt zr=%b got %0d want 12", zr, wr_addr_q.size() - wb);
      end
      for (int e = 0; e < 12; e++) begin
         ii = e / 6; jj = (e / 2) % 3; kk = e % 2;
         ea = 11'(16 * ii + 4 * jj + kk);
         ei = 11'(100 * ii + 10 * jj + 2 + kk);
         eg = 10'(7 + ii + kk);
         if (wb + e < wr_addr_q.size()) begin
            checks++;
            if (wr_addr_q[wb+e] !== ea || wr_cyc_q[wb+e] != n + 4 + e ||
                wr_zero_q[wb+e] !== zr) begin
               errors++;
               $display("FAIL nest_wr%0d zr=%b got %0d@%0d z%b want %0d@%0d z%b", e, zr,
                        wr_addr_q[wb+e], wr_cyc_q[wb+e], wr_zero_q[wb+e], ea, n + 4 + e, zr);
            end
         end
         if (!zr && ib + e < ird_q.size() && gb + e < grd_q.size()) begin
            checks++;
            if (ird_q[ib+e] !== ei || grd_q[gb+e] !== eg) begin
               errors++;
               $display("FAIL nest_rd%0d got inp %0d wgt %0d want %0d %0d", e,
                        ird_q[ib+e], grd_q[gb+e], ei, eg);
            end
         end
      end
      checks++;
      if (rd_cnt - rb != (zr ? 0 : 12)) begin
         errors++;
         $display("FAIL nest_rd_cnt zr=%b got %0d want %0d", zr, rd_cnt - rb, zr ? 0 : 12);
      end
      checks++;
      if (got && done_q[db] != n + 16) begin
         errors++;
         $display("FAIL nest_done_cyc zr=%b got %0d want %0d", zr, done_q[db], n + 16);
      end
      @(negedge clk);
   endtask

   task automatic test_loop_nest();
      run_nest(1'b0);
   endtask

   task automatic test_zero_mode();
      run_nest(1'b1);
   endtask

   task automatic test_degenerate();
      int n;
      bit got;
      for (int t = 0; t < 2; t++) begin
         if (t == 0) send_cmd(0, 2, 2, 0, 1, 1, 1, 1, 1, 1, 1'b0, n);
         else        send_cmd(3, 3, 2, 2, 1, 1, 1, 1, 1, 1, 1'b0, n);
         wait_done(got);
         checks++;
         if (!got || done_q[db] != n) begin
            errors++;
            $display("FAIL degen%0d_done got %0d want pulse at %0d", t,
                     got ? done_q[db] : -1, n);
         end
         checks++;
         if (f_q.size() - fb != 0 || rd_cnt - rb != 0 || wr_addr_q.size() - wb != 0) begin
            errors++;
            $display("FAIL degen%0d_strobes got f%0d r%0d w%0d want 0", t,
                     f_q.size() - fb, rd_cnt - rb, wr_addr_q.size() - wb);
         end
         @(negedge clk);
         #1;
         checks++;
         if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL degen%0d_ready got %b want 1", t, cmd_ready);
         end
      end
   endtask

   task automatic test_wrap();
      int n;
      bit got;
      m_acc[0] = 11'd2040; m_inp[0] = 11'd0; m_wgt[0] = 10'd1020;
      send_cmd(0, 1, 2, 1, 10, 0, 0, 0, 10, 0, 1'b0, n);
      wait_done(got);
      checks++;
      if (!got || wr_addr_q.size() - wb != 2) begin
         errors++;
         $display("FAIL wrap_cnt got %0d want 2", wr_addr_q.size() - wb);
      end else begin
         checks++;
         if (wr_addr_q[wb] !== 11'd2040 || wr_addr_q[wb+1] !== 11'd2) begin
            errors++;
            $display("FAIL wrap_acc got %0d %0d want 2040 2", wr_addr_q[wb], wr_addr_q[wb+1]);
         end
      end
      checks++;
      if (grd_q.size() - gb != 2 || grd_q[gb] !== 10'd1020 || grd_q[gb+1] !== 10'd6) begin
         errors++;
         $display("FAIL wrap_wgt got cnt %0d want 1020 6", grd_q.size() - gb);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int n;
      bit seen;
      m_acc[0] = 11'd0;  m_acc[1] = 11'd1;
      send_cmd(0, 2, 2, 3, 16, 4, 0, 0, 0, 0, 1'b0, n);
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         #1;
         if (wr_addr_q.size() - wb >= 3) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL rstmid_wait got timeout want 3 writes");
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({uop_rd_en, inp_rd_en, wgt_rd_en, acc_rd_en, acc_wr_en,
           acc_wr_zero, busy, done} !== 8'h00 ||
          (uop_addr | acc_addr | acc_wr_addr) !== 11'd0) begin
         errors++;
         $display("FAIL rstmid_outputs got %b want 0", {uop_rd_en, inp_rd_en,
                  wgt_rd_en, acc_rd_en, acc_wr_en, acc_wr_zero, busy, done});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      checks++;
      if (wr_addr_q.size() - wb != 3 || done_q.size() - db != 0) begin
         errors++;
         $display("FAIL rstmid_quiet got wr %0d done %0d want 3 0",
                  wr_addr_q.size() - wb, done_q.size() - db);
      end
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_ready got ready %b busy %b want 1 0", cmd_ready, busy);
      end
   endtask

   task automatic test_raw();
      int n;
      bit got;
      int e_rd2, e_wr2;
      m_acc[4] = 11'd9; m_acc[5] = 11'd9;
      m_inp[4] = 11'd0; m_inp[5] = 11'd0;
      m_wgt[4] = 10'd0; m_wgt[5] = 10'd0;
`ifdef GEMM_RAW_STALL_EN
      e_rd2 = 5; e_wr2 = 7;
`else
      e_rd2 = 3; e_wr2 = 5;
`endif
      send_cmd(4, 6, 1, 1, 0, 0, 0, 0, 0, 0, 1'b0, n);
      wait_done(got);
      checks++;
      if (!got || ard_q.size() - ab != 2 || wr_addr_q.size() - wb != 2) begin
         errors++;
         $display("FAIL raw_cnt got rd %0d wr %0d want 2 2",
                  ard_q.size() - ab, wr_addr_q.size() - wb);
      end else begin
         checks++;
         if (ard_cyc_q[ab] != n + 2 || ard_cyc_q[ab+1] != n + e_rd2 ||
             ard_q[ab+1] !== 11'd9) begin
            errors++;
            $display("FAIL raw_rd got %0d %0d want %0d %0d", ard_cyc_q[ab] - n,
                     ard_cyc_q[ab+1] - n, 2, e_rd2);
         end
         checks++;
         if (wr_cyc_q[wb] != n + 4 || wr_cyc_q[wb+1] != n + e_wr2 ||
             wr_addr_q[wb] !== 11'd9 || wr_addr_q[wb+1] !== 11'd9) begin
            errors++;
            $display("FAIL raw_wr got %0d %0d want %0d %0d", wr_cyc_q[wb] - n,
                     wr_cyc_q[wb+1] - n, 4, e_wr2);
         end
         checks++;
         if (done_q[db] != n + e_wr2 + 1) begin
            errors++;
            $display("FAIL raw_done got %0d want %0d", done_q[db] - n, e_wr2 + 1);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_uop_bgn = '0; cmd_uop_end = '0;
      cmd_lp_out = '0; cmd_lp_in = '0;
      cmd_acc_f_out = '0; cmd_acc_f_in = '0;
      cmd_inp_f_out = '0; cmd_inp_f_in = '0;
      cmd_wgt_f_out = '0; cmd_wgt_f_in = '0;
      cmd_reset = 1'b0;
      for (int a = 0; a < 16; a++) begin
         m_acc[a] = '0; m_inp[a] = '0; m_wgt[a] = '0;
      end
      test_reset();
      test_single();
      test_loop_nest();
      test_zero_mode();
      test_degenerate();
      test_wrap();
      test_raw();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gemm_loop_seq.md
Name: gemm_loop_seq

Overview:
Sequencer for the GEMM systolic datapath. It accepts one GEMM command and walks a two-level loop nest over a micro-op (uop) range, fetching each uop. It then issues input, weight and accumulator buffer reads and retires an accumulator write once the MAC chain result is ready. It sits between the instruction decoder and the buffer SRAMs that feed the systolic column/row MAC arrays.

Parameters:
UOP_AW, 11, uop memory address width
ACC_AW, 11, accumulator buffer address width
INP_AW, 11, input buffer address width
WGT_AW, 10, weight buffer address width
LOOP_W, 14, loop extent width
RD_LAT, 1, inp/wgt/acc SRAM read latency in cycles (>=1)
MAC_LAT, 1, datapath cycles from read data valid to result valid (>=0)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_uop_bgn / cmd_uop_end  in  UOP_AW each  uop range [bgn,end)
cmd_lp_out / cmd_lp_in  in  LOOP_W each  outer/inner extents
cmd_acc_f_out / cmd_acc_f_in  in  ACC_AW each  acc strides
cmd_inp_f_out / cmd_inp_f_in  in  INP_AW each  inp strides
cmd_wgt_f_out / cmd_wgt_f_in  in  WGT_AW each  wgt strides
cmd_reset  in  1  zero-fill mode
uop_rd_en / uop_addr  out  1 / UOP_AW  uop fetch
uop_acc / uop_inp / uop_wgt  in  ACC_AW / INP_AW / WGT_AW  uop fields, valid exactly 1 cycle after uop_rd_en
inp_rd_en / inp_addr, wgt_rd_en / wgt_addr, acc_rd_en / acc_addr  out  1 / widths  buffer reads
acc_wr_en / acc_wr_addr / acc_wr_zero  out  1 / ACC_AW / 1  writeback strobe, address, write-zero select
busy  out  1  high from accept until done
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: every output is 0 except cmd_ready=1. FSM goes to IDLE. Pipeline valid bits are cleared.
- FSM states are IDLE, RUN, DRAIN and DONE.
- IDLE: cmd_ready=1. On cmd_valid, all cmd fields are latched and busy=1.
  - If cmd_lp_out==0, cmd_lp_in==0, or cmd_uop_end<=cmd_uop_bgn, go to DONE: no memory access is issued.
  - Otherwise go to RUN.
- RUN: one uop is issued per cycle. Loop order is i (outer, 0..lp_out-1), j (inner, 0..lp_in-1), k (uop_bgn..uop_end-1, innermost).
  - Offsets are running sums, with no multipliers: off_x = i*x_f_out + j*x_f_in.
  - Sums and address adds wrap modulo 2^AW.
  - After the last (i,j,k) issue, go to DRAIN.
- Pipeline for a uop fetched at cycle n:
  - n+1: uop fields arrive.
  - n+2: registered read addresses are driven: acc_addr = uop_acc+off_acc, inp_addr = uop_inp+off_inp, wgt_addr = uop_wgt+off_wgt.
  - n+2+RD_LAT+MAC_LAT: acc_wr_en=1, with acc_wr_addr equal to that acc_addr.
  - Offsets travel with the uop in the pipeline.
- cmd_reset=1: inp/wgt/acc rd_en stay low. The write still occurs at the same latency with acc_wr_zero=1. Otherwise acc_wr_zero=0.
- DRAIN: no new issues. When the pipeline is empty, go to DONE.
- DONE: done=1 for one cycle, busy=0 next cycle, return to IDLE. cmd_ready is 0 outside IDLE.
- Throughput: one write per cycle in steady state. No bubbles at loop boundaries.
- rst mid-operation: in-flight work is discarded immediately. No further writes, and no done pulse.
- Without the optional feature, accumulator RAW hazards are the compiler's responsibility; there is no interlock.

Optional Feature:
GEMM_RAW_STALL_EN
- Defined: before driving acc_addr at stage n+2, the block compares it against acc_wr_addr of every valid in-flight uop that has not yet written.
  - On a match: hold stage n+2, hold the fetched uop fields, and suppress uop_rd_en. Release the cycle after the matching write.
  - cmd_reset commands never stall.
- Undefined: no comparators, no stall.

Test Plan:
- Single op: bgn=0, end=1, lp_out=lp_in=1, uop={acc 5, inp 3, wgt 7}, fetch at cycle n.
  - Required: uop_addr=0 at n. Reads acc 5 / inp 3 / wgt 7 at n+2. acc_wr_addr=5 at n+4 (defaults). done one cycle after the write.
- Loop nest: lp_out=2, lp_in=3, uops acc{0,1}, acc_f_out=16, acc_f_in=4.
  - Required: 12 writes in order 0,1,4,5,8,9,16,17,20,21,24,25 on consecutive cycles.
- Zero mode: cmd_reset=1, same nest.
  - Required: identical write addresses with acc_wr_zero=1, and inp/wgt/acc rd_en never high.
- Degenerate commands: lp_in=0, then uop_end==uop_bgn.
  - Required: no rd/wr strobes, done pulse, cmd_ready back to 1.
- Reset mid-op: rst asserted after the 3rd write of the loop-nest case.
  - Required: all outputs 0 immediately, no further acc_wr_en, no done, cmd_ready=1 after release.
- GEMM_RAW_STALL_EN: two uops both acc=9, lp=1x1.
  - Required: second acc_rd is delayed until the cycle after the first write, and the second write lands 1 cycle after the first write plus the stall length.
  - Without the macro: writes occur on back-to-back cycles.
